// File: rtl/ofm_pkg.sv
// Shared types and constants for the OFM write buffer: drain FSM encoding and
// the leaky-ReLU shift amount used when OFM_LEAKY_RELU_EN is defined.
package ofm_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StDrain = 1'b1
    } ofm_state_e;

    localparam int unsigned LeakyShift = 3;

endpackage

// File: rtl/ofm_leaky_relu.sv
// Combinational leaky ReLU: negative two's-complement values are scaled by 1/8
// through an arithmetic right shift; non-negative values pass through.
module ofm_leaky_relu
    import ofm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (data_i[DATA_WIDTH-1]) begin
            data_o = $unsigned($signed(data_i) >>> LeakyShift);
        end
    end

endmodule

// File: rtl/ofm_write_buffer.sv
// Ping-pong OFM write buffer: captures whole systolic columns and streams them out
// one element per cycle. Optional leaky ReLU on the output path via OFM_LEAKY_RELU_EN.
module ofm_write_buffer
    import ofm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned SYSTOLIC_SIZE = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load,
    input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] data_in,
    output logic                              ready,
    output logic                              write,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              done,
    output logic                              overflow
);

    localparam int unsigned CntW = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
    localparam int unsigned ColW = SYSTOLIC_SIZE * DATA_WIDTH;
    localparam logic [CntW-1:0] CntLast = CntW'(SYSTOLIC_SIZE - 1);

    logic [ColW-1:0]       bank_q [2];
    logic [1:0]            full_q;
    logic                  fill_ptr_q;
    logic                  drain_ptr_q;
    logic [CntW-1:0]       cnt_q;
    ofm_state_e            state_q;
    logic                  write_q;
    logic                  done_q;
    logic                  overflow_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic                  accept;
    logic                  drain_now;
    logic                  last_elem;
    logic                  other_full;
    logic [DATA_WIDTH-1:0] elem_raw;
    logic [DATA_WIDTH-1:0] elem_out;

    assign ready      = ~(full_q[0] & full_q[1]);
    assign accept     = load & ready;
    assign drain_now  = full_q[drain_ptr_q];
    assign last_elem  = (cnt_q == CntLast);
    assign other_full = full_q[~drain_ptr_q];
    assign elem_raw   = bank_q[drain_ptr_q][cnt_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef OFM_LEAKY_RELU_EN
    ofm_leaky_relu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_leaky_relu (
        .data_i (elem_raw),
        .data_o (elem_out)
    );
`else
    assign elem_out = elem_raw;
`endif

    // Storage is intentionally left out of reset; full flags gate its use.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_q[fill_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= 2'b00;
            fill_ptr_q  <= 1'b0;
            drain_ptr_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StIdle;
            write_q     <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            data_q      <= '0;
        end else begin
            done_q  <= 1'b0;
            write_q <= drain_now;

            if (load && !ready) begin
                overflow_q <= 1'b1;
            end

            // Fill and drain always target different banks when both act on one edge.
            if (accept) begin
                full_q[fill_ptr_q] <= 1'b1;
                fill_ptr_q         <= ~fill_ptr_q;
            end

            if (drain_now) begin
                data_q <= elem_out;
                if (last_elem) begin
                    full_q[drain_ptr_q] <= 1'b0;
                    drain_ptr_q         <= ~drain_ptr_q;
                    cnt_q               <= '0;
                    done_q              <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (drain_now && !(last_elem && !other_full)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!drain_now || (last_elem && !other_full)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign write    = write_q;
    assign data_out = data_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ofm_write_buffer.sv
// Directed self-checking bench for ofm_write_buffer with hand-computed expected values.
module tb_ofm_write_buffer;

    localparam int DW = 16;
    localparam int SS = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load;
    logic [SS*DW-1:0] data_in;
    logic             ready;
    logic             write;
    logic [DW-1:0]    data_out;
    logic             done;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ofm_write_buffer #(
        .DATA_WIDTH    (DW),
        .SYSTOLIC_SIZE (SS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .data_in  (data_in),
        .ready    (ready),
        .write    (write),
        .data_out (data_out),
        .done     (done),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_col(input logic [15:0] base);
        for (int i = 0; i < SS; i++) begin
            data_in[i*DW +: DW] = base + 16'(i);
        end
    endtask

    task automatic do_reset();
        load  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Loads A (0x100+i) then B (0x200+i) back to back; optionally a third load while
    // both banks are full, or a load C (0x300+i) on the cycle ready rises.
    task automatic run_stream(input bit third, input bit append, input string name);
        int            n;
        logic [15:0]   exp_d;
        logic          exp_rdy;
        n = append ? 48 : 32;
        @(negedge clk);
        set_col(16'h100);
        load = 1'b1;
        @(negedge clk);
        check({name, " ready_one_full"}, 32'(ready), 32'd1);
        check({name, " write_pre"}, 32'(write), 32'd0);
        set_col(16'h200);
        load = 1'b1;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            exp_d   = 16'(((j / 16) + 1) * 256 + (j % 16));
            exp_rdy = (j >= 15) && !(append && j >= 16 && j <= 30);
            check($sformatf("%s write[%0d]", name, j), 32'(write), 32'd1);
            check($sformatf("%s data[%0d]", name, j), 32'(data_out), 32'(exp_d));
            check($sformatf("%s done[%0d]", name, j), 32'(done), 32'((j % 16) == 15));
            check($sformatf("%s ready[%0d]", name, j), 32'(ready), 32'(exp_rdy));
            check($sformatf("%s ovf[%0d]", name, j), 32'(overflow), 32'(third && j >= 1));
            load = 1'b0;
            if ((third && j == 0) || (append && j == 15)) begin
                set_col(16'h300);
                load = 1'b1;
            end
        end
        @(negedge clk);
        check({name, " write_end"}, 32'(write), 32'd0);
        check({name, " done_end"}, 32'(done), 32'd0);
        check({name, " data_hold"}, 32'(data_out), append ? 32'h30F : 32'h20F);
        check({name, " ovf_end"}, 32'(overflow), 32'(third));
    endtask

    initial begin
        int wcnt;
        rst_n   = 1'b0;
        load    = 1'b0;
        data_in = '0;
        #1;
        check("rst write", 32'(write), 32'd0);
        check("rst ready", 32'(ready), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst ovf", 32'(overflow), 32'd0);
        check("rst data", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single load of 1..16
        set_col(16'd1);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("single write_pre", 32'(write), 32'd0);
        for (int j = 0; j < SS; j++) begin
            @(negedge clk);
            check($sformatf("single write[%0d]", j), 32'(write), 32'd1);
            check($sformatf("single data[%0d]", j), 32'(data_out), 32'(j + 1));
            check($sformatf("single done[%0d]", j), 32'(done), 32'(j == SS - 1));
        end
        @(negedge clk);
        check("single write_end", 32'(write), 32'd0);
        check("single data_hold", 32'(data_out), 32'd16);

        do_reset();
        run_stream(1'b0, 1'b0, "two");
        do_reset();
        run_stream(1'b1, 1'b0, "ovf");

        // Reset mid-drain at element 5; overflow is still set from the previous run
        @(negedge clk);
        set_col(16'h500);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
        end
        check("mid data5", 32'(data_out), 32'h505);
        rst_n = 1'b0;
        #1;
        check("mid write", 32'(write), 32'd0);
        check("mid ready", 32'(ready), 32'd1);
        check("mid ovf", 32'(overflow), 32'd0);
        check("mid data", 32'(data_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wcnt = 0;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            if (write) wcnt++;
        end
        check("mid no_write_after", 32'(wcnt), 32'd0);

        do_reset();
        run_stream(1'b0, 1'b1, "append");

        // Leaky ReLU path
        do_reset();
        data_in = '0;
        data_in[0*DW +: DW] = 16'hFFC0;
        data_in[1*DW +: DW] = 16'd40;
        data_in[2*DW +: DW] = 16'h8000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
`ifdef OFM_LEAKY_RELU_EN
        check("leaky neg64", 32'(data_out), 32'hFFF8);
`else
        check("leaky neg64", 32'(data_out), 32'hFFC0);
`endif
        @(negedge clk);
        check("leaky pos40", 32'(data_out), 32'd40);
        @(negedge clk);
`ifdef OFM_LEAKY_RELU_EN
        check("leaky minval", 32'(data_out), 32'hF000);
`else
        check("leaky minval", 32'(data_out), 32'h8000);
`endif
        repeat (16) @(negedge clk);
        check("leaky write_end", 32'(write), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ofm_write_buffer.md
OFM_WRITE_BUFFER -- requirements
Module: ofm_write_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one OFM element.
REQ-002 SHALL have parameter SYSTOLIC_SIZE, default 16, number of elements per systolic output column.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load  input  1  data_in valid for capture this cycle.
REQ-006 SHALL have port data_in  input  SYSTOLIC_SIZE*DATA_WIDTH  one column; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port ready  output  1  at least one bank empty; load accepted only when high.
REQ-008 SHALL have port write  output  1  strobe to ofm_addr_controller; one element per high cycle.
REQ-009 SHALL have port data_out  output  DATA_WIDTH  element qualified by write.
REQ-010 SHALL have port done  output  1  one-cycle pulse with last element of a bank.
REQ-011 SHALL have port overflow  output  1  sticky; load seen while ready low.

Function
REQ-012 SHALL hold two banks (ping-pong) of SYSTOLIC_SIZE elements, each with a full flag.
REQ-013 SHALL capture data_in into the fill-pointer bank on the edge where load=1 and ready=1, set its full flag, toggle fill pointer.
REQ-014 SHALL drive ready = NOT(full0 AND full1), combinational from registered flags.
REQ-015 SHALL drain with FSM states IDLE and DRAIN; IDLE->DRAIN when drain-pointer bank full; DRAIN->IDLE after last element if other bank empty, else stay in DRAIN.
REQ-016 SHALL register write and data_out; first element of a bank captured at edge k appears with write=1 in cycle k+1 when idle.
REQ-017 SHALL emit elements of a bank in index order 0..SYSTOLIC_SIZE-1 on consecutive cycles, write held high throughout, no gaps.
REQ-018 SHALL, when the other bank is full at the last element, continue with its element 0 next cycle (no write bubble).
REQ-019 SHALL clear a bank's full flag and toggle drain pointer on the edge that registers its last element; done=1 in that same output cycle.
REQ-020 SHALL accept a load on the same edge a bank is freed only if ready was high before that edge (ready is not look-ahead).
REQ-021 SHALL ignore data_in when load=1 and ready=0, set overflow, leave banks and pointers unchanged.
REQ-022 SHALL use a drain element counter of $clog2(SYSTOLIC_SIZE) bits, wrapping to 0 after SYSTOLIC_SIZE-1.
REQ-023 SHALL hold data_out at last value when write=0.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear: full flags, pointers, counter, write=0, done=0, overflow=0, data_out=0, state=IDLE; ready reads 1.
REQ-025 SHALL discard any partially drained bank on mid-operation reset; no further write until new load after release.
REQ-026 SHALL not clear bank storage contents on reset.

Configuration
REQ-027 SHALL honour macro OFM_LEAKY_RELU_EN: defined -> negative elements (two's complement) output as arithmetic right shift by 3 (slope 1/8), non-negative unchanged, applied before the data_out register, latency unchanged.
REQ-028 SHALL, without OFM_LEAKY_RELU_EN, pass elements unmodified.

Structure
REQ-029 SHALL place state encoding (IDLE, DRAIN) and leaky shift constant (3) in shared package ofm_pkg.
REQ-030 SHALL optionally use one sub-module ofm_leaky_relu (combinational, DATA_WIDTH) instantiated only under OFM_LEAKY_RELU_EN.

Verification
REQ-031 Reset: rst_n=0 mid-drain at element 5 -> write=0, ready=1, overflow=0 immediately; no write after release until next load.
REQ-032 Single load, data_in element i = i+1 -> write high 16 cycles starting next cycle, data_out 1..16, done with 16, then write=0.
REQ-033 Two loads on consecutive cycles (A then B) -> 32 continuous write cycles, A then B, done at cycles 16 and 32, ready low only while both banks full.
REQ-034 Third load while both banks full -> ignored, overflow=1 and stays 1; output stream identical to REQ-033.
REQ-035 Load on the cycle ready rises during drain -> accepted, appended with no write gap.
REQ-036 OFM_LEAKY_RELU_EN defined, element -64 (0xFFC0) -> data_out -8 (0xFFF8); element 40 -> 40; undefined -> -64 unchanged.
